// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared encodings for the EX-stage multiply/divide unit:
//                mul/div operation codes and iterative-FSM state codes.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Operation select presented on the mul/div op bus (values 6-7 unused).
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Iterative engine states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Interface   : ex_muldiv_if
//  Description : Request/response bundle between the EX stage / hazard logic
//                (master) and the multiply/divide unit (slave).
//  Signals     : start, op[2:0], a, b, flush   master -> slave
//                busy, done, hi, lo            slave  -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, flush, output busy, done, hi, lo);
endinterface : ex_muldiv_if
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the mul/div engine.
//                Multiply: radix-2 shift-add on {upper product, multiplier}.
//                Divide  : restoring shift-subtract on {remainder, quotient}.
//  Ports       : i_part   [2W-1:0]  current partial product / {rem, quot}
//                i_opnd   [W-1:0]   multiplicand or divisor magnitude
//                i_is_div           1 = divide step, 0 = multiply step
//                o_next   [2W-1:0]  next partial (quotient LSB left at 0)
//                o_qbit             quotient bit produced by a divide step
//  Config      : MULDIV_DIV_EN  -- divider path present only when defined
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [2*WIDTH-1:0] i_part,
    input  wire logic [WIDTH-1:0]   i_opnd,
    input  wire logic               i_is_div,
    output logic      [2*WIDTH-1:0] o_next,
    output logic                    o_qbit
);
    logic [WIDTH:0] w_sum;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole pair right by one.
    always_comb begin
        w_sum = {1'b0, i_part[2*WIDTH-1:WIDTH]} +
                (i_part[0] ? {1'b0, i_opnd} : '0);
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // Divide: shift the next dividend bit into the remainder and try to
    // subtract. With rem < divisor the trial is < 2*divisor, so the
    // W+1-bit difference sign is exact.
    always_comb begin
        w_trial = i_part[2*WIDTH-1:WIDTH-1];
        w_diff  = w_trial - {1'b0, i_opnd};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_next = {w_diff[WIDTH-1:0], i_part[WIDTH-2:0], 1'b0};
                o_qbit = 1'b1;
            end else begin
                o_next = {w_trial[WIDTH-1:0], i_part[WIDTH-2:0], 1'b0};
                o_qbit = 1'b0;
            end
        end else begin
            o_next = {w_sum, i_part[WIDTH-1:1]};
            o_qbit = 1'b0;
        end
    end
`else
    logic w_unused_is_div;
    assign w_unused_is_div = i_is_div;

    always_comb begin
        o_next = {w_sum, i_part[WIDTH-1:1]};
        o_qbit = 1'b0;
    end
`endif

endmodule : muldiv_step
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative multiply/divide unit of the EX stage. Owns the
//                architectural HI/LO registers and raises busy while a
//                mul/div is in flight so hazard logic can stall.
//  Ports       : clock, reset (sync, active-high)
//                md (ex_muldiv_if.slave): start, op, a, b, flush -> in
//                                         busy, done, hi, lo     -> out
//  Config      : MULDIV_DIV_EN  -- defined: divider datapath present;
//                undefined: DIV/DIVU complete as no-ops with a done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic   clock,
    input  wire logic   reset,
    ex_muldiv_if.slave  md
);
    localparam int CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0]   opb_q,   opb_d;
    logic               neg_q,   neg_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
`ifdef MULDIV_DIV_EN
    logic               is_div_q,  is_div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               divz_q,    divz_d;
    logic [WIDTH-1:0]   w_quot, w_rem;
`endif

    md_op_e             w_op;
    logic               w_accept, w_signed, w_is_mul, w_is_div;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [2*WIDTH-1:0] w_step_next, w_prod;
    logic               w_step_qbit;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_part   (acc_q),
        .i_opnd   (opb_q),
`ifdef MULDIV_DIV_EN
        .i_is_div (is_div_q),
`else
        .i_is_div (1'b0),
`endif
        .o_next   (w_step_next),
        .o_qbit   (w_step_qbit)
    );

    always_comb begin
        w_op     = md_op_e'(md.op);
        w_accept = md.start && !busy_q && !md.flush;
        w_is_mul = (w_op == MD_MULT) || (w_op == MD_MULTU);
        w_is_div = (w_op == MD_DIV)  || (w_op == MD_DIVU);
        w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
        w_abs_a  = (w_signed && md.a[WIDTH-1]) ? -md.a : md.a;
        w_abs_b  = (w_signed && md.b[WIDTH-1]) ? -md.b : md.b;
        w_prod   = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        w_quot    = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        w_rem     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

        // Squash beats everything else, including a same-cycle start.
        if (md.flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (w_accept) begin
`ifdef MULDIV_DIV_EN
                        if (w_is_mul || w_is_div) begin
`else
                        if (w_is_mul) begin
`endif
                            state_d = MD_CALC;
                            cnt_d   = CW'(WIDTH - 1);
                            acc_d   = {{WIDTH{1'b0}}, w_abs_a};
                            opb_d   = w_abs_b;
                            neg_d   = w_signed && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
                            busy_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                            is_div_d  = w_is_div;
                            neg_rem_d = w_signed && md.a[WIDTH-1];
                            divz_d    = (md.b == '0);
`else
                        end else if (w_is_div) begin
                            // No divider: complete at once so stalls release.
                            done_d = 1'b1;
`endif
                        end else if (w_op == MD_MTHI) begin
                            hi_d = md.a;
                        end else if (w_op == MD_MTLO) begin
                            lo_d = md.a;
                        end
                    end
                end
                MD_CALC: begin
                    acc_d = {w_step_next[2*WIDTH-1:1], w_step_next[0] | w_step_qbit};
                    if (cnt_q == '0) begin
                        state_d = MD_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MD_FIX: begin
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        // Divide by zero: quotient all ones, remainder is the
                        // dividend (sign-restored |a| equals a).
                        lo_d = divz_q ? '1 : w_quot;
                        hi_d = w_rem;
                    end else begin
                        {hi_d, lo_d} = w_prod;
                    end
`else
                    {hi_d, lo_d} = w_prod;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = MD_IDLE;
                end
                default: begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
`endif
        end
    end

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule : ex_muldiv
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Directed self-checking bench for ex_muldiv. Divider vectors
//                are active when MULDIV_DIV_EN is defined; otherwise DIV/DIVU
//                are checked as single-cycle no-ops.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(32)) mif ();

    ex_muldiv #(.WIDTH(32)) u_dut (
        .clock (clk),
        .reset (rst),
        .md    (mif.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered #1 after a rising edge; the next edge is E0.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        @(posedge clk); #1;
        mif.start = 1'b0;
    endtask

    // Counts edges from E0 (edge 1) until done is seen; bounded.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 1;
        busy_cyc = 0;
        while (!mif.done && edges < 100) begin
            if (mif.busy) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cyc);
        launch(op, a, b);
        wait_done(edges, busy_cyc);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int edges, bcyc, seen_busy, seen_done;

    initial begin
        mif.start = 1'b0;
        mif.op    = 3'd0;
        mif.a     = '0;
        mif.b     = '0;
        mif.flush = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        check_eq("rst_busy", 64'(mif.busy), 64'd0);
        check_eq("rst_done", 64'(mif.done), 64'd0);
        check_eq("rst_hilo", {mif.hi, mif.lo}, 64'd0);

        // MULTU max * max
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, bcyc);
        check_eq("multu_lat", 64'(edges), 64'd34);
        check_eq("multu_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFE_0000_0001);
        step(1);
        check_eq("multu_done_pulse", 64'(mif.done), 64'd0);

        // MULT -3 * 7
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, edges, bcyc);
        check_eq("mult_neg_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check_eq("mult_busy_cyc", 64'(bcyc), 64'd33);

        run_op(MD_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, edges, bcyc);
        check_eq("mult_max_m1", {mif.hi, mif.lo}, 64'hFFFF_FFFF_8000_0001);
        run_op(MD_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, edges, bcyc);
        check_eq("mult_negneg", {mif.hi, mif.lo}, 64'h0000_0000_0000_001E);
        run_op(MD_MULTU, 32'h8000_0000, 32'd2, edges, bcyc);
        check_eq("multu_big", {mif.hi, mif.lo}, 64'h0000_0001_0000_0000);

`ifdef MULDIV_DIV_EN
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, edges, bcyc);
        check_eq("div_lat", 64'(edges), 64'd34);
        check_eq("div_m7_2", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIVU, 32'd100, 32'd0, edges, bcyc);
        check_eq("divu_by0", {mif.hi, mif.lo}, 64'h0000_0064_FFFF_FFFF);
        check_eq("divu_by0_lat", 64'(edges), 64'd34);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges, bcyc);
        check_eq("div_ovf", {mif.hi, mif.lo}, 64'h0000_0000_8000_0000);
        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, edges, bcyc);
        check_eq("div_7_m2", {mif.hi, mif.lo}, 64'h0000_0001_FFFF_FFFD);
        run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0, edges, bcyc);
        check_eq("div_neg_by0", {mif.hi, mif.lo}, 64'hFFFF_FFFB_FFFF_FFFF);
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd16, edges, bcyc);
        check_eq("divu_big", {mif.hi, mif.lo}, 64'h0000_000F_0FFF_FFFF);
`else
        // Without a divider DIV/DIVU leave HI/LO alone and pulse done after E0.
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, edges, bcyc);
        check_eq("nodiv_lat", 64'(edges), 64'd1);
        check_eq("nodiv_busy", 64'(bcyc), 64'd0);
        check_eq("nodiv_busy_now", 64'(mif.busy), 64'd0);
        check_eq("nodiv_hilo", {mif.hi, mif.lo}, 64'h0000_0001_0000_0000);
        step(1);
        check_eq("nodiv_done_pulse", 64'(mif.done), 64'd0);
        run_op(MD_DIVU, 32'd100, 32'd0, edges, bcyc);
        check_eq("nodivu_lat", 64'(edges), 64'd1);
        check_eq("nodivu_hilo", {mif.hi, mif.lo}, 64'h0000_0001_0000_0000);
`endif

        // MTHI / MTLO while idle
        launch(MD_MTHI, 32'h0000_1234, 32'd0);
        check_eq("mthi_hi", 64'(mif.hi), 64'h1234);
        check_eq("mthi_done", 64'(mif.done), 64'd0);
        check_eq("mthi_busy", 64'(mif.busy), 64'd0);
        launch(MD_MTLO, 32'h0000_5555, 32'd0);
        check_eq("mtlo_hilo", {mif.hi, mif.lo}, 64'h0000_1234_0000_5555);

        // Op 6 with start: nothing happens
        launch(3'd6, 32'hDEAD_BEEF, 32'd1);
        check_eq("op6_hilo", {mif.hi, mif.lo}, 64'h0000_1234_0000_5555);
        check_eq("op6_busy_done", {mif.busy, mif.done}, 64'd0);

        // Flush at E10 together with a new start
        launch(MD_MULT, 32'd3, 32'd7);
        step(9);
        check_eq("flush_pre_busy", 64'(mif.busy), 64'd1);
        mif.flush = 1'b1;
        mif.start = 1'b1;
        mif.op    = MD_MULTU;
        mif.a     = 32'd9;
        mif.b     = 32'd9;
        @(posedge clk); #1;
        mif.flush = 1'b0;
        mif.start = 1'b0;
        check_eq("flush_busy", 64'(mif.busy), 64'd0);
        check_eq("flush_done", 64'(mif.done), 64'd0);
        seen_busy = 0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.busy) seen_busy++;
            if (mif.done) seen_done++;
            @(posedge clk); #1;
        end
        check_eq("flush_no_relaunch", 64'(seen_busy), 64'd0);
        check_eq("flush_no_done", 64'(seen_done), 64'd0);
        check_eq("flush_hilo", {mif.hi, mif.lo}, 64'h0000_1234_0000_5555);

        // Start while busy is ignored
        launch(MD_MULTU, 32'd5, 32'd6);
        step(4);
        mif.start = 1'b1;
        mif.op    = MD_MTHI;
        mif.a     = 32'hDEAD;
        @(posedge clk); #1;
        mif.op    = MD_MULTU;
        mif.a     = 32'd100;
        mif.b     = 32'd100;
        @(posedge clk); #1;
        mif.start = 1'b0;
        wait_done(edges, bcyc);
        check_eq("busy_start_lat", 64'(edges + 6), 64'd34);
        check_eq("busy_start_hilo", {mif.hi, mif.lo}, 64'h0000_0000_0000_001E);

        // Reset at E20
        launch(MD_MTLO, 32'h77, 32'd0);
        launch(MD_MULTU, 32'd2, 32'd3);
        step(19);
        check_eq("rst_mid_busy_pre", 64'(mif.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_mid_outs", {mif.busy, mif.done, mif.hi, mif.lo}, 66'd0);
        seen_busy = 0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.busy) seen_busy++;
            if (mif.done) seen_done++;
            @(posedge clk); #1;
        end
        check_eq("rst_mid_quiet", 64'(seen_busy + seen_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ex_muldiv
`default_nettype wire
